// File: rtl/attn_av_scheduler.sv
// Control FSM for the attention A*V datapath: column/tile loads, multiplier issue, accumulate, writeback.
// Optional feature: define ATTN_SCHED_PERF_CNT_EN to add the 32-bit busy-cycle counter output perf_cycles.
module attn_av_scheduler #(
  parameter int NUM_COLS    = 8,
  parameter int NUM_TILES   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2*NUM_COLS-1:0]        precision_sel,
  input  logic                         mul_valid,
  output logic                         load_col,
  output logic                         load_tile,
  output logic                         compute_valid,
  output logic                         accum_en,
  output logic                         store_out,
  output logic [$clog2(NUM_COLS)-1:0]  col_idx,
  output logic [$clog2(NUM_TILES)-1:0] tile_idx,
  output logic [1:0]                   cur_prec,
  output logic                         busy,
  output logic                         done,
  output logic                         error
`ifdef ATTN_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int TW = $clog2(NUM_TILES);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(NUM_COLS - 1);
  localparam logic [TW-1:0] LAST_TILE = TW'(NUM_TILES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_COL, S_LOAD_TILE, S_ISSUE, S_WAIT, S_ACCUM, S_STORE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [TW-1:0]         tile_q, tile_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [2*NUM_COLS-1:0] prec_q, prec_d;
  logic                  err_q, err_d;
  logic [CW:0]           prec_base;

  // Multiplier latency in cycles; the reserved code 11 behaves as FP16.
  function automatic int latency(input logic [1:0] p);
    case (p)
      2'b00:   latency = 1;
      2'b01:   latency = 2;
      default: latency = 4;
    endcase
  endfunction

  assign prec_base = {col_q, 1'b0};
  assign cur_prec  = prec_q[prec_base +: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      tile_q  <= '0;
      wait_q  <= '0;
      prec_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tile_q  <= tile_d;
      wait_q  <= wait_d;
      prec_q  <= prec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tile_d  = tile_q;
    wait_d  = wait_q;
    prec_d  = prec_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prec_d  = precision_sel;
          col_d   = '0;
          tile_d  = '0;
          err_d   = 1'b0;
          state_d = S_LOAD_COL;
        end
      end
      S_LOAD_COL, S_LOAD_TILE: state_d = S_ISSUE;
      S_ISSUE: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving before the precision's latency has elapsed is spurious.
        wait_d = wait_q + 1'b1;
        if (mul_valid && (int'(wait_q) + 1 >= latency(cur_prec))) begin
          state_d = S_ACCUM;
        end else if (int'(wait_q) + 1 >= TIMEOUT_CYC) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_ACCUM: begin
        if (tile_q != LAST_TILE) begin
          tile_d  = tile_q + 1'b1;
          state_d = S_LOAD_TILE;
        end else if (col_q != LAST_COL) begin
          col_d   = col_q + 1'b1;
          tile_d  = '0;
          state_d = S_LOAD_COL;
        end else begin
          state_d = S_STORE;
        end
      end
      S_STORE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_col      = (state_q == S_LOAD_COL);
  assign load_tile     = (state_q == S_LOAD_TILE);
  assign compute_valid = (state_q == S_ISSUE);
  assign accum_en      = (state_q == S_ACCUM);
  assign store_out     = (state_q == S_STORE);
  assign done          = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign col_idx       = col_q;
  assign tile_idx      = tile_q;
  assign error         = err_q;

`ifdef ATTN_SCHED_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE) begin
      if (start) perf_d = '0;
    end else begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_attn_av_scheduler.sv
// Scoreboard bench for attn_av_scheduler: stimulus queues expected job/reset outcomes, a monitor checks them.
module tb_attn_av_scheduler;

  localparam int K_JOB = 1;
  localparam int K_RST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] precision_sel;
  logic        mul_valid = 1'b0;
  logic        load_col, load_tile, compute_valid, accum_en, store_out;
  logic [2:0]  col_idx;
  logic [1:0]  tile_idx;
  logic [1:0]  cur_prec;
  logic        busy, done, error;
`ifdef ATTN_SCHED_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  attn_av_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .precision_sel(precision_sel),
    .mul_valid    (mul_valid),
    .load_col     (load_col),
    .load_tile    (load_tile),
    .compute_valid(compute_valid),
    .accum_en     (accum_en),
    .store_out    (store_out),
    .col_idx      (col_idx),
    .tile_idx     (tile_idx),
    .cur_prec     (cur_prec),
    .busy         (busy),
    .done         (done),
    .error        (error)
`ifdef ATTN_SCHED_PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int first_load;
    int first_accum;
    int done_cyc;
    int n_accum;
    int n_store;
    int err_c0;
    int err_c1;
    int err_done;
    int prec0;
    int perf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   resp_mode = 0;  // 0: never answer, 1: answer resp_lat cycles after issue, 2: hold high
  int   resp_lat = 1;
  bit   fin_req = 0;
  bit   fin_ack = 0;

  logic [14:0] outs;
  assign outs = {load_col, load_tile, compute_valid, accum_en, store_out,
                 col_idx, tile_idx, cur_prec, busy, done, error};

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Multiplier-array responder
  initial begin
    forever begin
      @(negedge clk);
      if (resp_mode == 2) begin
        mul_valid = 1'b1;
      end else if (resp_mode == 1 && compute_valid) begin
        mul_valid = 1'b0;
        for (int k = 0; k < resp_lat; k++) @(posedge clk);
        #1 mul_valid = 1'b1;
        @(posedge clk);
        #1 mul_valid = 1'b0;
      end else begin
        mul_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   rst_last = 1'b0;
    bit   in_job = 1'b0;
    int   job_cyc = 0;
    int   n_acc = 0;
    int   n_st = 0;
    int   first_ld = -1;
    int   first_ac = -1;
    int   err0 = 0;
    int   err1 = 0;
    int   prec1 = 0;
`ifdef ATTN_SCHED_PERF_CNT_EN
    bit   perf_pend = 1'b0;
    int   perf_exp = 0;
`endif
    forever begin
      @(negedge clk);
`ifdef ATTN_SCHED_PERF_CNT_EN
      if (perf_pend) begin
        chk("perf_cycles", int'(perf_cycles), perf_exp);
        perf_pend = 1'b0;
      end
`endif
      if (rst_last && !rst) begin
        if (exp_q.size() == 0) begin
          chk("rst_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rst_kind", e.kind, K_RST);
          chk("rst_outputs", int'(outs), 0);
        end
        in_job = 1'b0;
      end else if (!rst) begin
        if (start && !busy) begin
          job_cyc  = 0;
          n_acc    = 0;
          n_st     = 0;
          first_ld = -1;
          first_ac = -1;
          err0     = int'(error);
          in_job   = 1'b1;
        end else begin
          job_cyc++;
        end
        if (in_job) begin
          if (job_cyc == 1) begin
            err1  = int'(error);
            prec1 = int'(cur_prec);
          end
          if (load_col && first_ld < 0) first_ld = job_cyc;
          if (accum_en) begin
            n_acc++;
            if (first_ac < 0) first_ac = job_cyc;
          end
          if (store_out) n_st++;
          if (done) begin
            if (exp_q.size() == 0) begin
              chk("done_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              chk("job_kind", e.kind, K_JOB);
              chk("first_load_col", first_ld, e.first_load);
              chk("first_accum", first_ac, e.first_accum);
              chk("done_cycle", job_cyc, e.done_cyc);
              chk("accum_pulses", n_acc, e.n_accum);
              chk("store_pulses", n_st, e.n_store);
              chk("error_at_start", err0, e.err_c0);
              chk("error_cycle1", err1, e.err_c1);
              chk("error_at_done", int'(error), e.err_done);
              chk("cur_prec_col0", prec1, e.prec0);
`ifdef ATTN_SCHED_PERF_CNT_EN
              perf_exp  = e.perf;
              perf_pend = 1'b1;
`endif
            end
            in_job = 1'b0;
          end else if (job_cyc > 400) begin
            chk("job_no_done", job_cyc, 0);
            in_job = 1'b0;
          end
        end
      end
      if (fin_req && !fin_ack) begin
        chk("queue_drained", exp_q.size(), 0);
        fin_ack = 1'b1;
      end
      rst_last = rst;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    exp_t e;
    e = '{K_RST, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
    rst = 1'b1;
    step(cycles);
    rst = 1'b0;
    step(2);
  endtask

  // Runs one job; the precision input is scrambled after start to exercise the snapshot.
  task automatic run_job(input logic [15:0] sel, input int mode, input int lat,
                         input int busy_start_at, input exp_t e);
    precision_sel = sel;
    resp_mode     = mode;
    resp_lat      = lat;
    exp_q.push_back(e);
    start = 1'b1;
    step(1);
    start = 1'b0;
    precision_sel = ~sel;
    for (int i = 1; i < 420; i++) begin
      start = (i == busy_start_at);
      if (done) break;
      step(1);
    end
    start = 1'b0;
    step(2);
    resp_mode = 0;
    step(1);
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    precision_sel = '0;
    do_reset(3);

    run_job(16'h0000, 1, 1, -1, '{K_JOB, 1, 4, 130, 32, 1, 0, 0, 0, 0, 130});
    run_job(16'hBBBB, 1, 4, -1, '{K_JOB, 1, 7, 226, 32, 1, 0, 0, 0, 3, 226});
    run_job(16'h0001, 2, 1, -1, '{K_JOB, 1, 5, 134, 32, 1, 0, 0, 0, 1, 134});
    run_job(16'h0000, 0, 1, -1, '{K_JOB, 1, -1, 19, 0, 0, 0, 0, 1, 0, 19});
    run_job(16'h0000, 1, 1, 40, '{K_JOB, 1, 4, 130, 32, 1, 1, 0, 0, 0, 130});
    run_job(16'h0000, 0, 1, -1, '{K_JOB, 1, -1, 19, 0, 0, 0, 0, 1, 0, 19});

    // Reset in IDLE with the sticky error set
    do_reset(2);

    // Reset in the middle of WAIT
    precision_sel = 16'h0000;
    resp_mode     = 0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(9);
    do_reset(2);

    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_ack; i++) step(1);
    if (!fin_ack) begin
      $display("FAIL final_handshake: got 0 expected 1");
      $fatal(1, "monitor stalled");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
